// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 data mux between eight requesters.
// Bounded grant hold, one-cycle break-before-make gap, registered mux output.
module mux8_rr_scheduler #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y_q,
    output logic       y_valid
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state, state_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] sel_nxt, ptr, ptr_nxt, pick, cand;
    logic [3:0] cnt, cnt_nxt;
    logic       found, release_now;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = !req[sel] || (cnt == HOLD_LIM) || !en;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (en && found) begin
                    gnt_nxt   = 8'b1 << pick;
                    sel_nxt   = pick;
                    cnt_nxt   = 4'd1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = sel + 3'd1;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            y_q     <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            // y_q keeps its last sample through GAP/IDLE; y_valid says whether it is fresh.
            y_valid <= (state == GRANT);
            if (state == GRANT) y_q <= d[sel];
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: transaction-level model checked every cycle on two
// instances (HOLD_MAX=4 and HOLD_MAX=1), plus directed scenarios with literal expectations.
module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] d = '0;

    logic [7:0] gnt4, gnt1;
    logic [2:0] sel4, sel1;
    logic       busy4, busy1, yq4, yq1, yv4, yv1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_rr_scheduler #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .d(d),
        .gnt(gnt4), .sel(sel4), .busy(busy4), .y_q(yq4), .y_valid(yv4)
    );

    mux8_rr_scheduler #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .d(d),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .y_q(yq1), .y_valid(yv1)
    );

    // Model: who owns the mux (-1 = nobody), how long they've held it, whether
    // the break gap is pending, and where the next search starts.
    typedef struct {
        int owner;
        int sel;
        int ptr;
        int held;
        bit gap;
        bit yq;
        bit yv;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = -1; m.sel = 0; m.ptr = 0; m.held = 0;
        m.gap = 1'b0; m.yq = 1'b0; m.yv = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int hold, logic [7:0] r, logic [7:0] dv, logic e);
        mdl_t n = m;
        n.yv = (m.owner >= 0);
        if (m.owner >= 0) begin
            n.yq = dv[m.sel];
            if (!r[m.owner] || m.held == hold || !e) begin
                n.ptr   = (m.owner + 1) % 8;
                n.owner = -1;
                n.gap   = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else if (m.gap) begin
            n.gap = 1'b0;
        end else if (e && r != 0) begin
            for (int k = 0; k < 8; k++)
                if (n.owner < 0 && r[(m.ptr + k) % 8]) begin
                    n.owner = (m.ptr + k) % 8;
                    n.sel   = n.owner;
                    n.held  = 1;
                end
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_gnt(mdl_t m);
        return (m.owner >= 0) ? 8'(1 << m.owner) : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m, input logic [7:0] g, input logic [2:0] s,
                            input logic b, input logic yq, input logic yv);
        chk({tag, ".gnt"}, 32'(g), 32'(exp_gnt(m)));
        chk({tag, ".sel"}, 32'(s), 32'(m.sel));
        chk({tag, ".busy"}, 32'(b), 32'((m.owner >= 0) || m.gap));
        chk({tag, ".y_q"}, 32'(yq), 32'(m.yq));
        chk({tag, ".y_valid"}, 32'(yv), 32'(m.yv));
        chk({tag, ".onehot0"}, 32'($onehot0(g)), 32'd1);
    endtask

    // Model advances on every active edge, and resets the instant rst_n falls.
    initial begin
        m4 = mdl_reset();
        m1 = mdl_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m4 = mdl_reset();
                m1 = mdl_reset();
            end else begin
                m4 = mdl_step(m4, 4, req, d, en);
                m1 = mdl_step(m1, 1, req, d, en);
            end
        end
    end

    // Grant history of the HOLD_MAX=4 instance for the directed scenarios.
    int   g_idx[$];
    int   g_len[$];
    logic g_y[$];
    int   h1_max;

    initial begin
        logic [7:0] prev4, prev1;
        int run4, run1;
        prev4 = '0; prev1 = '0; run4 = 0; run1 = 0; h1_max = 0;
        forever begin
            @(negedge clk);
            cmp_inst("dut4", m4, gnt4, sel4, busy4, yq4, yv4);
            cmp_inst("dut1", m1, gnt1, sel1, busy1, yq1, yv1);
            if (!rst_n) begin
                g_idx.delete(); g_len.delete(); g_y.delete();
                prev4 = '0; prev1 = '0; run4 = 0; run1 = 0; h1_max = 0;
            end else begin
                if (gnt4 != 0 && prev4 == 0) begin
                    for (int i = 0; i < 8; i++) if (gnt4[i]) g_idx.push_back(i);
                    run4 = 1;
                end else if (gnt4 != 0) begin
                    run4++;
                end else if (prev4 != 0) begin
                    g_len.push_back(run4);
                    g_y.push_back(yq4);
                end
                run1 = (gnt1 != 0) ? run1 + 1 : 0;
                if (run1 > h1_max) h1_max = run1;
                prev4 = gnt4;
                prev1 = gnt1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic e, input logic [7:0] r, input logic [7:0] dv);
        rst_n = 1'b0;
        step(1);
        en    = e;
        req   = r;
        d     = dv;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst.gnt", 32'(gnt4), 32'h00);
        chk("rst.sel", 32'(sel4), 32'd0);
        chk("rst.busy", 32'(busy4), 32'd0);
        chk("rst.y_valid", 32'(yv4), 32'd0);

        // Async reset mid-GRANT, then first grant after release
        do_reset(1'b1, 8'h20, 8'hAA);
        step(2);
        chk("midgrant.gnt", 32'(gnt4), 32'h20);
        chk("midgrant.sel", 32'(sel4), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("async.gnt", 32'(gnt4), 32'h00);
        chk("async.sel", 32'(sel4), 32'd0);
        chk("async.busy", 32'(busy4), 32'd0);
        chk("async.y_valid", 32'(yv4), 32'd0);
        step(1);
        req = 8'h01;
        rst_n = 1'b1;
        step(1);
        chk("post_rst.gnt", 32'(gnt4), 32'h01);

        // Steady single request with regrant after GAP+IDLE
        do_reset(1'b1, 8'h08, 8'hAA);
        step(1);
        chk("single.gnt", 32'(gnt4), 32'h08);
        chk("single.sel", 32'(sel4), 32'd3);
        chk("single.yv_lag", 32'(yv4), 32'd0);
        step(4);
        chk("single.gap_gnt", 32'(gnt4), 32'h00);
        chk("single.gap_busy", 32'(busy4), 32'd1);
        chk("single.yv_trail", 32'(yv4), 32'd1);
        chk("single.y_q", 32'(yq4), 32'd1);
        step(1);
        chk("single.idle_busy", 32'(busy4), 32'd0);
        chk("single.idle_yv", 32'(yv4), 32'd0);
        step(1);
        chk("single.regrant", 32'(gnt4), 32'h08);
        chk("single.ngrants", 32'(g_idx.size()), 32'd2);
        chk("single.len", 32'(g_len[0]), 32'd4);

        // All requesting: 0..7 then 0, 4 cycles each, y_q alternating
        do_reset(1'b1, 8'hFF, 8'hAA);
        step(50);
        chk("all.ngrants", 32'(g_idx.size()), 32'd9);
        chk("all.nlens", 32'(g_len.size()), 32'd8);
        for (int i = 0; i < 9; i++) chk($sformatf("all.order%0d", i), 32'(g_idx[i]), 32'(i % 8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("all.len%0d", i), 32'(g_len[i]), 32'd4);
            chk($sformatf("all.y%0d", i), 32'(g_y[i]), 32'(i & 1));
        end
        chk("hold1.maxlen", 32'(h1_max), 32'd1);

        // Early drop of the granted request
        do_reset(1'b1, 8'h20, 8'h00);
        step(2);
        req = 8'h04;
        step(1);
        chk("drop.gnt", 32'(gnt4), 32'h00);
        chk("drop.busy", 32'(busy4), 32'd1);
        chk("drop.mdl_ptr", 32'(m4.ptr), 32'd6);
        req = 8'h24;
        step(3);
        chk("drop.ngrants", 32'(g_idx.size()), 32'd2);
        chk("drop.first", 32'(g_idx[0]), 32'd5);
        chk("drop.len", 32'(g_len[0]), 32'd2);
        chk("drop.next", 32'(g_idx[1]), 32'd2);

        // Pointer wrap 7 -> 0
        do_reset(1'b1, 8'h40, 8'h00);
        step(1);
        req = 8'h82;
        step(14);
        chk("wrap.ngrants", 32'(g_idx.size()), 32'd3);
        chk("wrap.g0", 32'(g_idx[0]), 32'd6);
        chk("wrap.g1", 32'(g_idx[1]), 32'd7);
        chk("wrap.g2", 32'(g_idx[2]), 32'd1);

        // Enable drop forces release; en=0 blocks grants; raising en grants at ptr
        do_reset(1'b1, 8'hFF, 8'h00);
        step(2);
        chk("en.gnt", 32'(gnt4), 32'h01);
        en = 1'b0;
        step(1);
        chk("en.release", 32'(gnt4), 32'h00);
        chk("en.gap_busy", 32'(busy4), 32'd1);
        step(8);
        chk("en.blocked_busy", 32'(busy4), 32'd0);
        chk("en.blocked_ngrants", 32'(g_idx.size()), 32'd1);
        en = 1'b1;
        step(1);
        chk("en.regrant", 32'(gnt4), 32'h02);
        chk("en.regrant_sel", 32'(sel4), 32'd1);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) req = req ^ 8'(1 << $urandom_range(0, 7));
            d = 8'($urandom);
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_scheduler.md
Name: mux8_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 data mux between eight requesters.
- Picks one requester at a time and drives the mux select and a one-hot grant.
- Holds each grant for a bounded time, then inserts a one-cycle break-before-make gap.
- Registers the selected data bit so downstream logic sees a clean, qualified output.

Parameters:
- HOLD_MAX, 4, maximum consecutive GRANT cycles per grant; legal range 1..15; held in a 4-bit counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scheduler enable; 0 blocks new grants and forces release of a current grant.
- req  input  8  request lines; bit i = requester i.
- d  input  8  mux data inputs; bit i is the data of requester i.
- gnt  output  8  one-hot grant (registered); all-zero when no grant.
- sel  output  3  mux select (registered); index of the current or last grant.
- busy  output  1  high while state is GRANT or GAP.
- y_q  output  1  registered mux output d[sel].
- y_valid  output  1  high when y_q holds a value sampled during GRANT.

Behaviour:
- Reset (async, rst_n=0): all of the following take effect immediately, independent of clk.
  - Outputs: state=IDLE, gnt=0, sel=0, busy=0, y_q=0, y_valid=0.
  - Internal: priority pointer ptr=0, hold counter cnt=0.
- Reset release: the first active edge is the first rising clk edge with rst_n=1.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching ptr, ptr+1, ... modulo 8.
  - On the next edge: gnt=one-hot(idx), sel=idx, cnt=1, state=GRANT.
  - Otherwise remain in IDLE; gnt=0; sel holds.
  - Latency: req sampled at edge N gives gnt at N+1.
- GRANT:
  - Each edge: y_q<=d[sel] and y_valid<=1.
  - Release when any of the following is sampled at an edge:
    - req[sel]=0, or
    - cnt==HOLD_MAX, or
    - en=0.
  - On release: gnt<=0, ptr<=(sel+1) mod 8 (3-bit wrap, 7->0), state<=GAP. sel holds.
  - Otherwise: cnt<=cnt+1 and gnt/sel hold.
- GAP:
  - Lasts exactly one cycle, then state=IDLE.
  - gnt=0; y_valid<=0; y_q holds its last value.
  - The minimum spacing between grants is therefore 2 cycles of gnt=0 (GAP, then IDLE).
- y_valid: registered as (state==GRANT). It trails gnt by one cycle and stays high for one cycle after gnt falls.
- Requests:
  - req changes on non-granted bits during GRANT are ignored.
  - Simultaneous requests are resolved only by ptr order, never by index.
- Single requester: a requester re-requesting alone is regranted after GAP+IDLE, whatever ptr is.
- Invariant: gnt is always zero or one-hot; gnt[sel]=1 whenever busy and in GRANT.
- Reset mid-GRANT: gnt drops immediately with no GAP; ptr restarts at 0.
- HOLD_MAX=1: every grant lasts exactly one cycle.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-GRANT (sel=5) -> gnt=0, sel=0, busy=0, y_valid=0 before the next clk edge. After release, req=8'h01 -> gnt=8'h01 one edge later.
2. Steady single request: d=8'b10101010, req=8'b00001000, HOLD_MAX=4 -> gnt=8'h08 and sel=3 for 4 cycles, y_q=1, y_valid high for 4 cycles (lagging gnt by one), GAP, IDLE, then regrant to 3 (ptr=4 wraps the search).
3. All requesting: req=8'hFF, HOLD_MAX=4 -> grant order 0,1,2,...,7,0. Each grant lasts 4 cycles followed by 2 zero cycles. y_q sequence 0,1,0,1,0,1,0,1.
4. Early drop: grant to 5, req[5] falls after 2 GRANT cycles -> release at that edge, GAP, ptr=6. With req=8'b00100100, the next grant goes to 2 (search 6,7,0,1,2).
5. Wrap-around: after a grant to 6, req=8'b10000010 -> next grant is 7, then 1 (ptr 7->0 wrap).
6. Enable: en dropped during GRANT -> release at the next edge and GAP. With en=0 and req=8'hFF held -> gnt stays 0 in IDLE. Raising en -> grant on the following edge to ptr.
